// File: rtl/instr_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
package instr_pkg;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_B = 2'b01,
    IMM_S = 2'b10,
    IMM_U = 2'b11
  } imm_src_t;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10
  } enc_state_t;

  // True when v survives truncation to a 'bits'-wide signed field.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic [31:0] hi;
    hi = 32'($signed(v) >>> (bits - 1));
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Harness-side stream and memory load port of the instruction encoder.
interface instr_encoder_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                   start;
  logic [ADDR_WIDTH-1:0]  base_addr;
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_last;
  instr_pkg::imm_src_t    imm_src;
  logic [6:0]             opcode;
  logic [2:0]             funct3;
  logic [4:0]             rd;
  logic [4:0]             rs1;
  logic [4:0]             rs2;
  logic [31:0]            imm;
  logic                   wr_en;
  logic                   wr_ready;
  logic [ADDR_WIDTH-1:0]  wr_addr;
  logic [31:0]            wr_data;
  logic                   busy;
  logic                   done;
  logic [7:0]             err_count;

  modport master (
    output start, base_addr, in_valid, in_last, imm_src, opcode, funct3, rd, rs1, rs2, imm,
           wr_ready,
    input  in_ready, wr_en, wr_addr, wr_data, busy, done, err_count
  );

  modport slave (
    input  start, base_addr, in_valid, in_last, imm_src, opcode, funct3, rd, rs1, rs2, imm,
           wr_ready,
    output in_ready, wr_en, wr_addr, wr_data, busy, done, err_count
  );
endinterface

// File: rtl/imm_pack.sv
// Packs decoded fields back into an RV32I word; range_ok_o is only computed
// when IMM_RANGE_CHECK_EN is defined, otherwise every immediate is accepted.
module imm_pack
  import instr_pkg::*;
(
  input  imm_src_t    imm_src_i,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        range_ok_o
);

  always_comb begin
    word_o = '0;
    case (imm_src_i)
      IMM_I:   word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
      IMM_S:   word_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
      IMM_B:   word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                         imm_i[4:1], imm_i[11], opcode_i};
      IMM_U:   word_o = {imm_i[31:12], rd_i, opcode_i};
      default: word_o = '0;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  always_comb begin
    range_ok_o = 1'b1;
    case (imm_src_i)
      IMM_I, IMM_S: range_ok_o = fits_signed(imm_i, 12);
      IMM_B:        range_ok_o = fits_signed(imm_i, 13) && !imm_i[0];
      IMM_U:        range_ok_o = (imm_i[11:0] == 12'h000);
      default:      range_ok_o = 1'b1;
    endcase
  end
`else
  assign range_ok_o = 1'b1;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Streams decoded instructions into consecutive instruction-memory words.
// IMM_RANGE_CHECK_EN enables rejection of unencodable immediates and err_count.
//
// state    | meaning
// ST_IDLE  | waiting for start; in_ready low
// ST_RUN   | accepting instructions, one-slot output register
// ST_DRAIN | last accepted; waiting for the output slot to empty
module instr_encoder
  import instr_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic            clk,
  input logic            rst_n,
  instr_encoder_if.slave bus
);

  enc_state_t            state_q;
  logic                  wr_en_q;
  logic                  done_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;

  logic [31:0] word;
  logic        range_ok;
  logic        in_ready;
  logic        accept;
  logic        wr_fire;

  imm_pack u_imm_pack (
    .imm_src_i  (bus.imm_src),
    .opcode_i   (bus.opcode),
    .funct3_i   (bus.funct3),
    .rd_i       (bus.rd),
    .rs1_i      (bus.rs1),
    .rs2_i      (bus.rs2),
    .imm_i      (bus.imm),
    .word_o     (word),
    .range_ok_o (range_ok)
  );

  assign in_ready = (state_q == ST_RUN) && (!wr_en_q || bus.wr_ready);
  assign accept   = bus.in_valid && in_ready;
  assign wr_fire  = wr_en_q && bus.wr_ready;

  // wr_addr_q always names the next word to be written, so a word accepted
  // on the same edge a write completes lands on the advanced address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      wr_en_q   <= 1'b0;
      done_q    <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (wr_fire) begin
        wr_en_q   <= 1'b0;
        wr_addr_q <= wr_addr_q + ADDR_WIDTH'(4);
      end
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q   <= ST_RUN;
            wr_addr_q <= bus.base_addr;
          end
        end
        ST_RUN: begin
          if (accept) begin
            if (range_ok) begin
              wr_en_q   <= 1'b1;
              wr_data_q <= word;
            end
            if (bus.in_last) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!wr_en_q) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef IMM_RANGE_CHECK_EN
  logic [7:0] err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else if (state_q == ST_IDLE && bus.start) begin
      err_q <= '0;
    end else if (accept && !range_ok && err_q != 8'hFF) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign bus.err_count = err_q;
`else
  assign bus.err_count = '0;
`endif

  assign bus.in_ready = in_ready;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = done_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encoding table, backpressure, range
// rejection (IMM_RANGE_CHECK_EN aware), address wrap and async reset.
module tb_instr_encoder;
  import instr_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_encoder_if #(.ADDR_WIDTH(32)) bus_a ();
  instr_encoder_if #(.ADDR_WIDTH(8))  bus_b ();

  instr_encoder #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  instr_encoder #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

  int total = 0;
  int bad   = 0;

  int          cyc = 0;
  int          done_cnt = 0;
  int          last_done_cyc = 0;
  logic [31:0] wa_addr[$];
  logic [31:0] wa_data[$];
  int          wa_cyc[$];
  logic [7:0]  wb_addr[$];
  logic [31:0] wb_data[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && bus_a.wr_en && bus_a.wr_ready) begin
      wa_addr.push_back(bus_a.wr_addr);
      wa_data.push_back(bus_a.wr_data);
      wa_cyc.push_back(cyc);
    end
    if (rst_n && bus_a.done) begin
      done_cnt      <= done_cnt + 1;
      last_done_cyc <= cyc;
    end
    if (rst_n && bus_b.wr_en && bus_b.wr_ready) begin
      wb_addr.push_back(bus_b.wr_addr);
      wb_data.push_back(bus_b.wr_data);
    end
  end

  typedef struct {
    imm_src_t    src;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_write(input int k, input logic [31:0] ea, input logic [31:0] ed);
    if (k < wa_addr.size()) begin
      chk($sformatf("wr_addr[%0d]", k), wa_addr[k], ea);
      chk($sformatf("wr_data[%0d]", k), wa_data[k], ed);
    end else begin
      total++;
      bad++;
      $display("FAIL missing_write[%0d]: got none want addr 0x%08h", k, ea);
    end
  endtask

  task automatic clear_mon();
    wa_addr.delete();
    wa_data.delete();
    wa_cyc.delete();
    wb_addr.delete();
    wb_data.delete();
  endtask

  task automatic drive(input imm_src_t s, input logic [6:0] op, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm, input logic last);
    bus_a.imm_src  = s;
    bus_a.opcode   = op;
    bus_a.funct3   = f3;
    bus_a.rd       = rd;
    bus_a.rs1      = rs1;
    bus_a.rs2      = rs2;
    bus_a.imm      = imm;
    bus_a.in_last  = last;
    bus_a.in_valid = 1'b1;
  endtask

  // Called just after a negedge; returns at the negedge after the transfer.
  task automatic wait_accept();
    logic hs;
    int   n = 0;
    forever begin
      #1;
      hs = bus_a.in_ready;
      @(posedge clk);
      if (hs) break;
      @(negedge clk);
      n++;
      if (n > 50) begin
        total++;
        bad++;
        $display("FAIL accept_timeout_a: got no in_ready want handshake");
        break;
      end
    end
    @(negedge clk);
    bus_a.in_valid = 1'b0;
  endtask

  task automatic wait_accept_b();
    logic hs;
    int   n = 0;
    forever begin
      #1;
      hs = bus_b.in_ready;
      @(posedge clk);
      if (hs) break;
      @(negedge clk);
      n++;
      if (n > 50) begin
        total++;
        bad++;
        $display("FAIL accept_timeout_b: got no in_ready want handshake");
        break;
      end
    end
    @(negedge clk);
    bus_b.in_valid = 1'b0;
  endtask

  task automatic start_prog(input logic [31:0] base);
    bus_a.start     = 1'b1;
    bus_a.base_addr = base;
    @(posedge clk);
    @(negedge clk);
    bus_a.start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus_a.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus_a.busy) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got busy=1 want 0");
    end
    @(negedge clk);
  endtask

  initial begin
    int d0;
    vecs[0] = '{IMM_I, OP_IMM,     3'd0, 5'd1,  5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFF0_0093};
    vecs[1] = '{IMM_B, OP_BRANCH,  3'd0, 5'd0,  5'd0, 5'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3};
    vecs[2] = '{IMM_S, OP_STORE,   3'd2, 5'd0,  5'd2, 5'd5, 32'h0000_0008, 32'h0051_2423};
    vecs[3] = '{IMM_U, OP_LUI,     3'd0, 5'd10, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_5537};
    vecs[4] = '{IMM_I, OP_IMM,     3'd0, 5'd3,  5'd4, 5'd0, 32'hFFFF_F800, 32'h8002_0193};
    vecs[5] = '{IMM_B, OP_BRANCH,  3'd1, 5'd0,  5'd1, 5'd2, 32'h0000_0FFE, 32'h7E20_9FE3};
    vecs[6] = '{IMM_S, OP_STORE,   3'd2, 5'd0,  5'd0, 5'd1, 32'hFFFF_FFFF, 32'hFE10_2FA3};
    vecs[7] = '{IMM_U, 7'b0010111, 3'd0, 5'd31, 5'd0, 5'd0, 32'hFFFF_F000, 32'hFFFF_FF97};

    bus_a.start = 1'b0; bus_a.base_addr = '0; bus_a.in_valid = 1'b0; bus_a.in_last = 1'b0;
    bus_a.imm_src = IMM_I; bus_a.opcode = '0; bus_a.funct3 = '0; bus_a.rd = '0;
    bus_a.rs1 = '0; bus_a.rs2 = '0; bus_a.imm = '0; bus_a.wr_ready = 1'b1;
    bus_b.start = 1'b0; bus_b.base_addr = '0; bus_b.in_valid = 1'b0; bus_b.in_last = 1'b0;
    bus_b.imm_src = IMM_I; bus_b.opcode = '0; bus_b.funct3 = '0; bus_b.rd = '0;
    bus_b.rs1 = '0; bus_b.rs2 = '0; bus_b.imm = '0; bus_b.wr_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(bus_a.in_ready), 32'd0);
    chk("rst_wr_en", 32'(bus_a.wr_en), 32'd0);
    chk("rst_wr_addr", bus_a.wr_addr, 32'd0);
    chk("rst_wr_data", bus_a.wr_data, 32'd0);
    chk("rst_busy", 32'(bus_a.busy), 32'd0);
    chk("rst_done", 32'(bus_a.done), 32'd0);
    chk("rst_err", 32'(bus_a.err_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single I-type with start and in_valid in the same cycle.
    clear_mon();
    d0 = done_cnt;
    bus_a.start = 1'b1;
    bus_a.base_addr = 32'h100;
    drive(IMM_I, OP_IMM, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b1);
    #1 chk("in_ready_in_idle", 32'(bus_a.in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus_a.start = 1'b0;
    wait_accept();
    wait_idle();
    chk("single_count", 32'(wa_addr.size()), 32'd1);
    chk_write(0, 32'h100, 32'hFFF0_0093);
    chk("single_done_cnt", 32'(done_cnt - d0), 32'd1);
    if (wa_cyc.size() > 0)
      chk("done_latency", 32'(last_done_cyc - wa_cyc[0]), 32'd2);

    // Encoding table streamed back-to-back as one program.
    clear_mon();
    start_prog(32'h100);
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].src, vecs[i].op, vecs[i].f3, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
            vecs[i].imm, (i == 7));
      wait_accept();
    end
    wait_idle();
    chk("table_count", 32'(wa_addr.size()), 32'd8);
    for (int i = 0; i < 8; i++) chk_write(i, 32'h100 + 32'(4 * i), vecs[i].exp_word);

    // Backpressure: two stall cycles on the second write.
    clear_mon();
    start_prog(32'h100);
    drive(IMM_I, OP_IMM, 3'd0, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0);
    wait_accept();
    drive(IMM_I, OP_IMM, 3'd0, 5'd2, 5'd0, 5'd0, 32'd2, 1'b0);
    wait_accept();
    bus_a.wr_ready = 1'b0;
    drive(IMM_I, OP_IMM, 3'd0, 5'd3, 5'd0, 5'd0, 32'd3, 1'b1);
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("stall_in_ready", 32'(bus_a.in_ready), 32'd0);
      chk("stall_wr_en", 32'(bus_a.wr_en), 32'd1);
      chk("stall_wr_data", bus_a.wr_data, 32'h0020_0113);
      chk("stall_wr_addr", bus_a.wr_addr, 32'h104);
      @(posedge clk);
      @(negedge clk);
    end
    bus_a.wr_ready = 1'b1;
    wait_accept();
    wait_idle();
    chk("bp_count", 32'(wa_addr.size()), 32'd3);
    chk_write(0, 32'h100, 32'h0010_0093);
    chk_write(1, 32'h104, 32'h0020_0113);
    chk_write(2, 32'h108, 32'h0030_0193);

    // Out-of-range immediates.
    clear_mon();
    start_prog(32'h100);
    drive(IMM_I, OP_IMM, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0);
    wait_accept();
    drive(IMM_B, OP_BRANCH, 3'd0, 5'd0, 5'd0, 5'd0, 32'd3, 1'b0);
    wait_accept();
    drive(IMM_I, OP_IMM, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
    wait_accept();
    wait_idle();
`ifdef IMM_RANGE_CHECK_EN
    chk("range_count", 32'(wa_addr.size()), 32'd1);
    chk_write(0, 32'h100, 32'h0050_0093);
    chk("range_err", 32'(bus_a.err_count), 32'd2);
`else
    chk("range_count", 32'(wa_addr.size()), 32'd3);
    chk_write(0, 32'h100, 32'h8000_0093);
    chk_write(1, 32'h104, 32'h0000_0163);
    chk_write(2, 32'h108, 32'h0050_0093);
    chk("range_err", 32'(bus_a.err_count), 32'd0);
`endif

    // Last instruction of the program is the unencodable one.
    clear_mon();
    d0 = done_cnt;
    start_prog(32'h100);
    drive(IMM_U, OP_LUI, 3'd0, 5'd2, 5'd0, 5'd0, 32'h0000_0001, 1'b1);
    wait_accept();
    wait_idle();
    chk("rej_last_done", 32'(done_cnt - d0), 32'd1);
`ifdef IMM_RANGE_CHECK_EN
    chk("rej_last_count", 32'(wa_addr.size()), 32'd0);
    chk("rej_last_err", 32'(bus_a.err_count), 32'd1);
`else
    chk("rej_last_count", 32'(wa_addr.size()), 32'd1);
    chk_write(0, 32'h100, 32'h0000_0137);
    chk("rej_last_err", 32'(bus_a.err_count), 32'd0);
`endif

    // 8-bit address wrap on the second instance.
    bus_b.start = 1'b1;
    bus_b.base_addr = 8'hFC;
    @(posedge clk);
    @(negedge clk);
    bus_b.start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus_b.imm_src = IMM_I; bus_b.opcode = OP_IMM; bus_b.funct3 = 3'd0;
      bus_b.rd = 5'd1; bus_b.rs1 = 5'd0; bus_b.rs2 = 5'd0; bus_b.imm = 32'(k);
      bus_b.in_last = (k == 1);
      bus_b.in_valid = 1'b1;
      wait_accept_b();
    end
    repeat (4) @(negedge clk);
    chk("wrap_busy", 32'(bus_b.busy), 32'd0);
    chk("wrap_count", 32'(wb_addr.size()), 32'd2);
    if (wb_addr.size() == 2) begin
      chk("wrap_addr0", 32'(wb_addr[0]), 32'h0000_00FC);
      chk("wrap_data0", wb_data[0], 32'h0000_0093);
      chk("wrap_addr1", 32'(wb_addr[1]), 32'h0000_0000);
      chk("wrap_data1", wb_data[1], 32'h0010_0093);
    end

    // Reset lands while a write is stalled.
    bus_b.start = 1'b1;
    bus_b.base_addr = 8'hFC;
    @(posedge clk);
    @(negedge clk);
    bus_b.start = 1'b0;
    bus_b.wr_ready = 1'b0;
    bus_b.imm = 32'd7;
    bus_b.in_last = 1'b1;
    bus_b.in_valid = 1'b1;
    wait_accept_b();
    chk("pre_rst_wr_en", 32'(bus_b.wr_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 32'(bus_b.in_ready), 32'd0);
    chk("arst_wr_en", 32'(bus_b.wr_en), 32'd0);
    chk("arst_wr_addr", 32'(bus_b.wr_addr), 32'd0);
    chk("arst_wr_data", bus_b.wr_data, 32'd0);
    chk("arst_busy", 32'(bus_b.busy), 32'd0);
    chk("arst_done", 32'(bus_b.done), 32'd0);
    chk("arst_err", 32'(bus_b.err_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
